// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module  : cache_controller
// Brief   : Direct-mapped write-back/write-allocate cache, 4 lines x 4 words,
//           acting as the initiator toward a 128-bit block main memory.
// Revision: 1.0
// ============================================================================
module cache_controller #(
    parameter int MEM_LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [9:0]   cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic         mem_read_write,
    output logic [9:0]   mem_address,
    output logic [127:0] mem_write_data,
    input  logic [127:0] mem_read_data
);

    localparam logic [3:0] C_CNT_LOAD = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    state_t         state_q;
    logic           req_we_q;
    logic [3:0]     req_tag_q;
    logic [1:0]     req_idx_q;
    logic [1:0]     req_off_q;
    logic [31:0]    req_wdata_q;
    logic [3:0]     cnt_q;
    logic [3:0]     valid_q;
    logic [3:0]     dirty_q;
    logic [3:0]     tag_q  [4];
    logic [31:0]    data_q [4][4];

    logic           cpu_ready_q;
    logic [31:0]    cpu_rdata_q;
    logic           mem_rw_q;
    logic [9:0]     mem_addr_q;
    logic [127:0]   mem_wdata_q;

    logic           w_hit;
    logic           w_fill;
    logic           w_hit_wr;
    logic [127:0]   w_victim;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];

    assign w_hit    = valid_q[req_idx_q] && (tag_q[req_idx_q] == req_tag_q);
    assign w_fill   = (state_q == ALLOCATE) && (cnt_q == 4'd0);
    assign w_hit_wr = (state_q == COMPARE) && w_hit && req_we_q;
    // Memory takes word0 in the top slice on writes.
    assign w_victim = {data_q[req_idx_q][0], data_q[req_idx_q][1],
                       data_q[req_idx_q][2], data_q[req_idx_q][3]};

    assign cpu_ready      = cpu_ready_q;
    assign cpu_rdata      = cpu_rdata_q;
    assign mem_read_write = mem_rw_q;
    assign mem_address    = mem_addr_q;
    assign mem_write_data = mem_wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_tag_q   <= 4'd0;
            req_idx_q   <= 2'd0;
            req_off_q   <= 2'd0;
            req_wdata_q <= 32'd0;
            cnt_q       <= 4'd0;
            valid_q     <= 4'd0;
            dirty_q     <= 4'd0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= 32'd0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= 10'd0;
            mem_wdata_q <= 128'd0;
        end else begin
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= 32'd0;
            case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        req_we_q    <= cpu_we;
                        req_tag_q   <= cpu_addr[9:6];
                        req_idx_q   <= cpu_addr[5:4];
                        req_off_q   <= cpu_addr[3:2];
                        req_wdata_q <= cpu_wdata;
                        state_q     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (w_hit) begin
                        cpu_ready_q <= 1'b1;
                        if (req_we_q) begin
                            dirty_q[req_idx_q] <= 1'b1;
                        end else begin
                            cpu_rdata_q <= data_q[req_idx_q][req_off_q];
                        end
                        state_q <= IDLE;
                    end else if (valid_q[req_idx_q] && dirty_q[req_idx_q]) begin
                        mem_addr_q  <= {tag_q[req_idx_q], req_idx_q, 4'b0000};
                        mem_wdata_q <= w_victim;
                        mem_rw_q    <= 1'b0;
                        cnt_q       <= C_CNT_LOAD;
                        state_q     <= WRITEBACK;
                    end else begin
                        mem_addr_q <= {req_tag_q, req_idx_q, 4'b0000};
                        cnt_q      <= C_CNT_LOAD;
                        state_q    <= ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    // Strobe stays low for the first cycle so each writeback has one rising edge.
                    if (cnt_q == 4'd0) begin
                        mem_rw_q           <= 1'b0;
                        dirty_q[req_idx_q] <= 1'b0;
                        mem_addr_q         <= {req_tag_q, req_idx_q, 4'b0000};
                        cnt_q              <= C_CNT_LOAD;
                        state_q            <= ALLOCATE;
                    end else begin
                        mem_rw_q <= 1'b1;
                        cnt_q    <= cnt_q - 4'd1;
                    end
                end
                ALLOCATE: begin
                    if (cnt_q == 4'd0) begin
                        valid_q[req_idx_q] <= 1'b1;
                        dirty_q[req_idx_q] <= 1'b0;
                        state_q            <= COMPARE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            tag_q[req_idx_q] <= req_tag_q;
            for (int k = 0; k < 4; k++) begin
                data_q[req_idx_q][k] <= mem_read_data[32*k +: 32];
            end
        end else if (w_hit_wr) begin
            data_q[req_idx_q][req_off_q] <= req_wdata_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// Scoreboard bench for cache_controller: a coherent-memory reference model
// predicts read data, completion latency and writeback contents.
`timescale 1ns/1ps
module tb_cache_controller;

    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req = 1'b0;
    logic         cpu_we = 1'b0;
    logic [9:0]   cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         mem_read_write;
    logic [9:0]   mem_address;
    logic [127:0] mem_write_data;
    logic [127:0] mem_read_data;

    cache_controller #(.MEM_LAT(LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_ready      (cpu_ready),
        .mem_read_write (mem_read_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_read;
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic [9:0]   addr;
        logic [127:0] data;
    } wb_t;

    logic [31:0] mem_words [256];
    logic [31:0] ref_mem   [256];
    logic        m_valid   [4];
    logic        m_dirty   [4];
    logic [3:0]  m_tag     [4];

    exp_t exp_q[$];
    wb_t  wb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Main memory: reads return word k in slice [32k +: 32].
    always_comb begin
        mem_read_data = '0;
        for (int k = 0; k < 4; k++) begin
            mem_read_data[32*k +: 32] = mem_words[int'(mem_address[9:4])*4 + k];
        end
    end

    // Writeback checker and memory write port: word k is taken from [127-32k -: 32].
    always @(posedge mem_read_write) begin
        wb_t w;
        if (rst_n) begin
            total++;
            if (wb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_writeback: addr=%h data=%h", mem_address, mem_write_data);
            end else begin
                w = wb_q.pop_front();
                if (mem_address !== w.addr || mem_write_data !== w.data) begin
                    bad++;
                    $display("FAIL writeback: got addr=%h data=%h want addr=%h data=%h",
                             mem_address, mem_write_data, w.addr, w.data);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            mem_words[int'(mem_address[9:4])*4 + k] = mem_write_data[127-32*k -: 32];
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (cpu_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ready: rdata=%h cycle=%0d", cpu_rdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e.due || (e.is_read && cpu_rdata !== e.data)) begin
                        bad++;
                        $display("FAIL response: got cycle=%0d rdata=%h want cycle=%0d rdata=%h (read=%0b)",
                                 cyc, cpu_rdata, e.due, e.data, e.is_read);
                    end
                end
            end else if (cpu_rdata !== 32'd0) begin
                total++;
                bad++;
                $display("FAIL rdata_idle: got %h want 00000000", cpu_rdata);
            end
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 4'd0;
        end
    endtask

    // Memory seen by the CPU is coherent; the tag model only predicts timing and victims.
    task automatic model(input logic we, input logic [9:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat);
        int  idx = int'(a[5:4]);
        int  w   = int'(a[9:2]);
        logic hit;
        wb_t wb;
        hit = m_valid[idx] && (m_tag[idx] == a[9:6]);
        if (hit) begin
            lat = 1;
        end else if (m_valid[idx] && m_dirty[idx]) begin
            lat = 2*LAT + 2;
            wb.addr = {m_tag[idx], 2'(idx), 4'b0000};
            for (int k = 0; k < 4; k++) begin
                wb.data[127-32*k -: 32] = ref_mem[int'(m_tag[idx])*16 + idx*4 + k];
            end
            wb_q.push_back(wb);
        end else begin
            lat = LAT + 2;
        end
        rd = ref_mem[w];
        if (we) ref_mem[w] = wd;
        m_dirty[idx] = (hit ? m_dirty[idx] : 1'b0) | we;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a[9:6];
    endtask

    task automatic issue(input logic we, input logic [9:0] a, input logic [31:0] wd);
        exp_t e;
        int   lat;
        logic [31:0] rd;
        model(we, a, wd, rd, lat);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk); #1;
        e.is_read = !we;
        e.data    = rd;
        e.due     = cyc + lat;
        exp_q.push_back(e);
        for (int n = 0; ; n++) begin
            if (cpu_ready) break;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL ready_timeout: addr=%h got no ready want ready", a);
                break;
            end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        for (int i = 0; i < 256; i++) begin
            mem_words[i] = $urandom;
            ref_mem[i]   = mem_words[i];
        end
        mem_words[4] = 32'hAAAA_0000; ref_mem[4] = 32'hAAAA_0000;
        mem_words[5] = 32'hBBBB_1111; ref_mem[5] = 32'hBBBB_1111;
        mem_words[6] = 32'hCCCC_2222; ref_mem[6] = 32'hCCCC_2222;
        mem_words[7] = 32'hDDDD_3333; ref_mem[7] = 32'hDDDD_3333;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready",  cpu_ready,      0);
        check("reset_rdata",  cpu_rdata,      0);
        check("reset_rw",     mem_read_write, 0);
        check("reset_addr",   mem_address,    0);
        check("reset_wdata",  mem_write_data, 0);
        @(negedge clk) rst_n = 1'b1;

        issue(1'b0, 10'h014, 32'd0);
        check("alloc_addr", mem_address, 10'h010);
        issue(1'b0, 10'h01C, 32'd0);
        check("hit_addr_hold", mem_address, 10'h010);
        check("hit_rw_low", mem_read_write, 0);

        issue(1'b1, 10'h014, 32'hDEAD_BEEF);
        issue(1'b0, 10'h110, 32'd0);
        issue(1'b0, 10'h014, 32'd0);

        issue(1'b1, 10'h204, 32'h1234_5678);
        issue(1'b0, 10'h2C4, 32'd0);

        // Reset during a writeback after its strobe has risen.
        issue(1'b1, 10'h014, 32'hCAFE_F00D);
        model(1'b0, 10'h114, 32'd0, rd, lat);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h114; cpu_wdata = 32'd0;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_rw_drop",    mem_read_write, 0);
        check("rst_ready_low",  cpu_ready,      0);
        check("rst_wb_done",    wb_q.size(),    0);
        cpu_req = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 10'h014, 32'd0);

        for (int i = 0; i < 300; i++) begin
            logic [9:0] a;
            a = {4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom)};
            issue(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("pending_responses",  exp_q.size(), 0);
        check("pending_writebacks", wb_q.size(),  0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
